// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus: instruction-cache request/response, execute redirect and the IF/ID register outputs.
// The master modport is the fetch unit's side; the slave modport is the cache/decode environment.
interface inst_fetch_unit_if;
    logic        icache_read;
    logic [30:0] icache_addr;
    logic [31:0] icache_rdata;
    logic        icache_stall;
    logic        icache_pcadd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_next;
    logic        id_is_rvc;

    modport master (
        output icache_read, icache_addr,
        output id_valid, id_instr, id_pc, id_pc_next, id_is_rvc,
        input  icache_rdata, icache_stall, icache_pcadd,
        input  redirect_valid, redirect_pc, id_stall
    );

    modport slave (
        input  icache_read, icache_addr,
        input  id_valid, id_instr, id_pc, id_pc_next, id_is_rvc,
        output icache_rdata, icache_stall, icache_pcadd,
        output redirect_valid, redirect_pc, id_stall
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: holds the PC, drives halfword addresses to the compressed-instruction cache
// and loads the IF/ID register, with decode back-pressure and redirects that may land mid-miss.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  proc_reset_n,
    inst_fetch_unit_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pending_pc, pending_pc_nxt;
    logic        valid_q, valid_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic [31:0] id_pc_q, id_pc_nxt;
    logic [31:0] link_q, link_nxt;
    logic        rvc_q, rvc_nxt;
    logic        read;
    logic [31:0] target;

    function automatic logic [31:0] pc_advance(input logic [31:0] base, input logic wide);
        return base + (wide ? 32'd4 : 32'd2);
    endfunction

    assign target = bus.redirect_pc & 32'hFFFF_FFFE;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) state <= IDLE;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pending_pc_nxt = pending_pc;
        valid_nxt      = valid_q;
        instr_nxt      = instr_q;
        id_pc_nxt      = id_pc_q;
        link_nxt       = link_q;
        rvc_nxt        = rvc_q;
        read           = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (bus.redirect_valid) pc_nxt = target;
            end
            FETCH: begin
                read = 1'b1;
                if (bus.redirect_valid) begin
                    valid_nxt = 1'b0;
                    // Mid-miss the cache address must stay put, so park the target until the miss drains.
                    if (bus.icache_stall) begin
                        pending_pc_nxt = target;
                        state_nxt      = DRAIN;
                    end else begin
                        pc_nxt = target;
                    end
                end else if (bus.icache_stall) begin
                    // A decode stall still holds a live instruction; only bubble when decode can accept.
                    if (!bus.id_stall) valid_nxt = 1'b0;
                end else if (!bus.id_stall) begin
                    valid_nxt = 1'b1;
                    instr_nxt = bus.icache_rdata;
                    id_pc_nxt = pc;
                    link_nxt  = pc_advance(pc, bus.icache_pcadd);
                    rvc_nxt   = ~bus.icache_pcadd;
                    pc_nxt    = pc_advance(pc, bus.icache_pcadd);
                end
            end
            DRAIN: begin
                read      = 1'b1;
                valid_nxt = 1'b0;
                if (bus.redirect_valid) pending_pc_nxt = target;
                if (!bus.icache_stall) begin
                    pc_nxt    = bus.redirect_valid ? target : pending_pc;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            pc         <= RESET_PC;
            pending_pc <= 32'h0;
            valid_q    <= 1'b0;
            instr_q    <= 32'h0;
            id_pc_q    <= 32'h0;
            link_q     <= 32'h0;
            rvc_q      <= 1'b0;
        end else begin
            pc         <= pc_nxt;
            pending_pc <= pending_pc_nxt;
            valid_q    <= valid_nxt;
            instr_q    <= instr_nxt;
            id_pc_q    <= id_pc_nxt;
            link_q     <= link_nxt;
            rvc_q      <= rvc_nxt;
        end
    end

    assign bus.icache_read = read;
    assign bus.icache_addr = pc[31:1];
    assign bus.id_valid    = valid_q;
    assign bus.id_instr    = instr_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_next  = link_q;
    assign bus.id_is_rvc   = rvc_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: expected IF/ID records are queued when a capture is driven
// and popped when the fetch unit presents them on the id_* outputs.
module tb_inst_fetch_unit;

    logic clk = 1'b0;
    logic proc_reset_n;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic        rvc;
    } rec_t;

    rec_t        sb[$];
    rec_t        last;
    logic        last_valid;
    int          total = 0;
    int          bad = 0;
    logic [31:0] ep;

    function automatic logic [31:0] mk(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, check the address, then check id_* after the rising edge.
    task automatic cyc(input logic pcadd, input logic cs, input logic ds, input logic rv,
                       input logic [31:0] rpc, input logic exp_read, input logic cap);
        rec_t r;
        bus.icache_pcadd   = pcadd;
        bus.icache_stall   = cs;
        bus.id_stall       = ds;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.icache_rdata   = mk(ep);
        #1;
        chk("icache_read", 32'(bus.icache_read), 32'(exp_read));
        chk("icache_addr", {1'b0, bus.icache_addr}, {1'b0, ep[31:1]});
        if (cap) begin
            sb.push_back({mk(ep), ep, ep + (pcadd ? 32'd4 : 32'd2), ~pcadd});
            ep = ep + (pcadd ? 32'd4 : 32'd2);
        end
        @(posedge clk);
        #1;
        if (cap) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL scoreboard_empty observed=0 expected=1");
            end else begin
                r = sb.pop_front();
                chk("id_valid", 32'(bus.id_valid), 32'd1);
                chk("id_instr", bus.id_instr, r.instr);
                chk("id_pc", bus.id_pc, r.pc);
                chk("id_pc_next", bus.id_pc_next, r.pc_next);
                chk("id_is_rvc", 32'(bus.id_is_rvc), 32'(r.rvc));
                last       = r;
                last_valid = 1'b1;
            end
        end else if (ds && !rv) begin
            chk("hold_valid", 32'(bus.id_valid), 32'(last_valid));
            chk("hold_instr", bus.id_instr, last.instr);
            chk("hold_pc", bus.id_pc, last.pc);
            chk("hold_pc_next", bus.id_pc_next, last.pc_next);
        end else begin
            chk("bubble_valid", 32'(bus.id_valid), 32'd0);
            last_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic redir(input logic [31:0] rpc);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, rpc, 1'b1, 1'b0);
        ep = {rpc[31:1], 1'b0};
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_read"}, 32'(bus.icache_read), 32'd0);
        chk({tag, "_addr"}, {1'b0, bus.icache_addr}, 32'h0000_0080);
        chk({tag, "_valid"}, 32'(bus.id_valid), 32'd0);
        chk({tag, "_instr"}, bus.id_instr, 32'h0);
        chk({tag, "_pc"}, bus.id_pc, 32'h0);
        chk({tag, "_pc_next"}, bus.id_pc_next, 32'h0);
        chk({tag, "_rvc"}, 32'(bus.id_is_rvc), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bus.icache_rdata   = 32'h0;
        bus.icache_stall   = 1'b0;
        bus.icache_pcadd   = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_stall       = 1'b0;
        proc_reset_n       = 1'b0;
        last               = '0;
        last_valid         = 1'b0;
        ep                 = 32'h0000_0100;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        proc_reset_n = 1'b1;

        // Reset and first fetch: IDLE cycle, then 0x100, 0x104, 0x108
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Mixed sizes from 0x200 (odd target bit dropped)
        redir(32'h0000_0201);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Five-cycle miss at 0x40
        redir(32'h0000_0040);
        repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Decode stall with id_pc=0x10
        redir(32'h0000_0010);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect to 0x801 in cycle 2 of a six-cycle miss at 0x40
        redir(32'h0000_0040);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0801, 1'b1, 1'b0);
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        ep = 32'h0000_0800;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Wrap: compressed at 0xFFFF_FFFE, then fetch from 0
        redir(32'hFFFF_FFFE);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect beats decode stall
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b0);
        ep = 32'h0000_0300;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Reset while draining a redirect: pending target is lost
        redir(32'h0000_0040);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0900, 1'b1, 1'b0);
        bus.icache_stall   = 1'b1;
        bus.redirect_valid = 1'b0;
        #2;
        proc_reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        proc_reset_n = 1'b1;
        ep = 32'h0000_0100;

        // Redirect seen in IDLE still loads the PC
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 1'b0, 1'b0);
        ep = 32'h0000_0500;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction-fetch stage that drives the read-only compressed-instruction cache and feeds decode. It holds the PC and issues halfword addresses to the cache. It advances the PC by 2 or 4 bytes according to the cache's instruction-size flag, and registers the fetched instruction into the IF/ID pipeline register. It also handles decode back-pressure and branch/jump redirects, including redirects that arrive while a cache miss is in flight.

## Interface
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset (bit 0 must be 0)

- clk  input  1  clock, all state updates on rising edge
- proc_reset_n  input  1  asynchronous active-low reset
- icache_read  output  1  fetch request to cache
- icache_addr  output  31  halfword address, equals pc[31:1]
- icache_rdata  input  32  instruction from cache; 32-bit, or decompressed 16-bit
- icache_stall  input  1  cache busy or miss; data not valid
- icache_pcadd  input  1  1: current instruction is 32-bit (advance 4); 0: compressed (advance 2)
- redirect_valid  input  1  taken branch/jump from execute; flushes IF/ID
- redirect_pc  input  32  redirect target byte address; bit 0 ignored (forced 0)
- id_stall  input  1  decode hazard; hold IF/ID and PC
- id_valid  output  1  IF/ID holds a live instruction
- id_instr  output  32  registered icache_rdata, unmodified
- id_pc  output  32  byte address of id_instr
- id_pc_next  output  32  id_pc + 4 (32-bit) or + 2 (compressed), link value for JAL/JALR
- id_is_rvc  output  1  registered ~icache_pcadd

## Operation
- State machine with states IDLE, FETCH and DRAIN.
- **IDLE** (entered on reset)
  - icache_read=0.
  - Next cycle goes to FETCH.
  - A redirect_valid seen in IDLE loads pc and still goes to FETCH.
- **FETCH**
  - icache_read=1.
  - Priority order: redirect_valid, then icache_stall, then id_stall.
  - redirect_valid with icache_stall=0: pc <= {redirect_pc[31:1],1'b0}, id_valid <= 0, stay FETCH.
  - redirect_valid with icache_stall=1: pending_pc <= {redirect_pc[31:1],1'b0}, id_valid <= 0, go to DRAIN. pc is unchanged so the cache address stays stable during the miss.
  - icache_stall=1, id_stall=0: pc holds, id_valid <= 0 (bubble).
  - id_stall=1, no redirect: pc and the whole IF/ID register hold.
  - Otherwise (capture), all of the following load on the same edge:
    - IF/ID loads id_instr=icache_rdata, id_pc=pc, id_pc_next=pc+inc, id_is_rvc=~icache_pcadd, id_valid=1.
    - pc <= pc+inc, where inc = icache_pcadd ? 4 : 2.
- **DRAIN**
  - icache_read=1, icache_addr=pc held, id_valid stays 0.
  - A new redirect_valid overwrites pending_pc.
  - When icache_stall=0: returned data is discarded, pc <= pending_pc, go to FETCH.
- **Arithmetic**
  - pc, id_pc and id_pc_next are 32-bit.
  - Addition wraps modulo 2^32: 32'hFFFF_FFFE + 2 = 0.

## Timing
- **Reset values:** state=IDLE, pc=RESET_PC, pending_pc=0, icache_read=0, icache_addr=RESET_PC[31:1], id_valid=0, id_instr=0, id_pc=0, id_pc_next=0, id_is_rvc=0.
- **Reset behaviour:** reset mid-miss or mid-DRAIN returns to these values immediately; any pending redirect is lost.
- **Hit path:** the instruction is visible on id_* one cycle after the edge where icache_read=1 and icache_stall=0. Sustained throughput is 1 instruction/cycle.
- **Miss path:** id_valid=0 on every cycle icache_stall=1. The capture happens on the first edge with icache_stall=0.
- **Redirect penalty:**
  - The first target instruction appears on id_* 2 cycles after the redirect_valid edge on a hit.
  - During a miss, it appears after the miss completes plus 2 cycles.
- **Flush vs. hold:** redirect_valid and id_stall in the same cycle: redirect wins and id_valid <= 0.
- **Address stability:** icache_addr never changes while icache_stall=1.
- **Outputs:** all outputs are registered except icache_read and icache_addr, which are decoded from state and pc.

## Test plan
- **Reset and first fetch:** reset with RESET_PC=32'h100; all hits, all 32-bit -> cycle 1 icache_read=0; then id_pc sequence 0x100, 0x104, 0x108, one per cycle, id_is_rvc=0.
- **Mixed sizes:** pcadd pattern 0,1,0 from pc 0x200 -> id_pc 0x200, 0x202, 0x206; id_pc_next 0x202, 0x206, 0x208.
- **Miss:** icache_stall held 5 cycles at pc 0x40 -> icache_addr stays 0x20, id_valid=0 for those cycles, then id_instr=icache_rdata with id_pc=0x40.
- **Decode stall:** id_stall=1 for 3 cycles while id_pc=0x10 -> id_* unchanged and pc unchanged; fetch resumes at 0x14.
- **Redirect during miss:** redirect_pc=0x801 asserted in cycle 2 of a 6-cycle miss at 0x40 -> icache_addr stays 0x20 until stall drops; 0x40 data never reaches IF/ID; next fetch icache_addr=0x400, id_pc=0x800.
- **Wrap and priority:** pc=0xFFFF_FFFE compressed -> next pc=0; redirect_valid with id_stall=1 -> id_valid=0 next cycle.
